au_incdec_pipe: RTL

- Pipelined incrementer/decrementer with valid/ready streaming handshake.
- Sits directly downstream of the prefix-AND propagate network (AU_prefix_and): forms propagate vector from the captured operand, feeds the prefix network, consumes its prefix output to form carries/borrows, result, overflow and zero flags.
- Building block for address counters, loop counters and +/-1 datapath units.

---
 rtl/au_incdec_pipe.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/au_incdec_pipe.sv
// au_incdec_pipe: two-stage pipelined +/-1 unit with a valid/ready stream on
// both sides. S1 captures the operand; the prefix-AND network, carry/borrow
// formation and optional saturation sit between S1 and S2; S2 drives outputs.
// AU_prefix_and: inclusive prefix-AND (po[i] = &p[i:0]) in a selectable
// topology, used to form the run-of-ones (inc) / run-of-zeros (dec) mask.

module AU_prefix_and #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] p_i,
  output logic [WIDTH-1:0] po_o
);

  localparam int LG = $clog2(WIDTH);

  logic [WIDTH-1:0] p_s;

  // Prefix network; every topology updates in place, since the operand read at
  // each level is never written on that same level.
  always_comb begin
    p_s = p_i;
    case (ARCH)
      32'sd1: begin
        // Brent-Kung: up-sweep builds block prefixes, down-sweep fills the gaps.
        for (int l = 0; l < LG; l++) begin
          for (int i = (2 << l) - 1; i < WIDTH; i += (2 << l)) begin
            p_s[i] = p_s[i] & p_s[i - (1 << l)];
          end
        end
        for (int l = LG - 2; l >= 0; l--) begin
          for (int i = 3 * (1 << l) - 1; i < WIDTH; i += (2 << l)) begin
            p_s[i] = p_s[i] & p_s[i - (1 << l)];
          end
        end
      end
      32'sd2: begin
        // Sklansky: at level l each bit with bit l of its index set picks up the
        // prefix ending just below its 2^l-aligned block.
        for (int l = 0; l < LG; l++) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (((i >> l) & 1) == 1) begin
              p_s[i] = p_s[i] & p_s[((i >> l) << l) - 1];
            end else begin
              p_s[i] = p_s[i];
            end
          end
        end
      end
      default: begin
        // Serial ripple chain.
        for (int i = 1; i < WIDTH; i++) begin
          p_s[i] = p_s[i] & p_s[i - 1];
        end
      end
    endcase
  end

  assign po_o = p_s;

endmodule

module au_incdec_pipe #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic             in_op,
  input  logic             in_ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic             out_co,
  output logic             out_zero
);

  localparam bit SAT_EN = (SAT != 0);

  // Stage 1: captured operand
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic             s1_op_q, s1_op_d;
  logic             s1_ci_q, s1_ci_d;
  // Stage 2: registered result
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_z_q, s2_z_d;
  logic             s2_co_q, s2_co_d;
  logic             s2_zero_q, s2_zero_d;

  logic             s2_adv_s, s1_adv_s, in_xfer_s;
  logic [WIDTH-1:0] pi_s, po_s, carry_s, raw_s, z_s;
  logic             co_s, zero_s;

  // Handshake: in_ready depends only on state and out_ready, never on in_valid.
  assign s2_adv_s  = ~s2_valid_q | out_ready;
  assign s1_adv_s  = s1_valid_q & s2_adv_s;
  assign in_ready  = ~s1_valid_q | s2_adv_s;
  assign in_xfer_s = in_valid & in_ready;

  // Increment ripples through trailing ones; decrement through trailing zeros.
  assign pi_s = s1_op_q ? ~s1_a_q : s1_a_q;

  AU_prefix_and #(.WIDTH(WIDTH), .ARCH(ARCH)) u_prefix (
    .p_i  (pi_s),
    .po_o (po_s)
  );

  // Carry/borrow into each bit: ci gated by the prefix of all lower bits.
  always_comb begin
    carry_s    = {WIDTH{1'b0}};
    carry_s[0] = s1_ci_q;
    for (int i = 1; i < WIDTH; i++) begin
      carry_s[i] = s1_ci_q & po_s[i - 1];
    end
  end

  assign raw_s = s1_a_q ^ carry_s;
  assign co_s  = s1_ci_q & po_s[WIDTH-1];

  // Saturation clamps to the range end in the direction of the step.
  always_comb begin
    z_s = raw_s;
    if (SAT_EN && co_s) begin
      z_s = s1_op_q ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
    end else begin
      z_s = raw_s;
    end
  end

  assign zero_s = (z_s == {WIDTH{1'b0}});

  // Stage 1 next state: load on input transfer, empty when drained into S2.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_op_d    = s1_op_q;
    s1_ci_d    = s1_ci_q;
    if (in_xfer_s) begin
      s1_valid_d = 1'b1;
      s1_a_d     = in_a;
      s1_op_d    = in_op;
      s1_ci_d    = in_ci;
    end else if (s1_adv_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2 next state: load from S1, empty on output transfer, else hold.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_z_d     = s2_z_q;
    s2_co_d    = s2_co_q;
    s2_zero_d  = s2_zero_q;
    if (s1_adv_s) begin
      s2_valid_d = 1'b1;
      s2_z_d     = z_s;
      s2_co_d    = co_s;
      s2_zero_d  = zero_s;
    end else if (s2_valid_q && out_ready) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= {WIDTH{1'b0}};
      s1_op_q    <= 1'b0;
      s1_ci_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_z_q     <= {WIDTH{1'b0}};
      s2_co_q    <= 1'b0;
      s2_zero_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_op_q    <= s1_op_d;
      s1_ci_q    <= s1_ci_d;
      s2_valid_q <= s2_valid_d;
      s2_z_q     <= s2_z_d;
      s2_co_q    <= s2_co_d;
      s2_zero_q  <= s2_zero_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_z     = s2_z_q;
  assign out_co    = s2_co_q;
  assign out_zero  = s2_zero_q;

endmodule
